pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush/halt controller with load-use stall and halt drain sequencing.
// Optional statistics counters are enabled with the PIPE_CTRL_STATS_EN macro.
module pipe_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int DEPTH    = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_halt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wrenable,
  input  logic             ex_mem_to_reg,
  input  logic             ex_jump_taken,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    STALL  = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [2:0] STALL_LOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(DEPTH - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;

  assign hazard = ex_mem_to_reg & ex_reg_wrenable & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The RUN cycle that detects a hazard is itself the first stall cycle, so STALL
  // leaves one count early; DRAIN counts all DEPTH bubbles after the halt advances.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b0;
    fd_en        = 1'b0;
    fd_flush     = 1'b0;
    id_ex_bubble = 1'b1;
    halted       = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_jump_taken) begin
          pc_en    = 1'b1;
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          state_d  = FLUSH;
        end else if (hazard) begin
          cnt_d   = STALL_LOAD;
          state_d = (LOAD_LAT > 1) ? STALL : RUN;
        end else if (id_halt) begin
          id_ex_bubble = 1'b0;
          cnt_d        = DRAIN_LOAD;
          state_d      = DRAIN;
        end else begin
          pc_en        = 1'b1;
          fd_en        = 1'b1;
          id_ex_bubble = 1'b0;
        end
      end
      STALL: begin
        cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RUN;
      end
      FLUSH: begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b1;
        state_d  = RUN;
      end
      DRAIN: begin
        cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        if (cnt_q == 3'd0) state_d = HALTED;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (!rst_n) begin
      pc_en        = 1'b0;
      fd_en        = 1'b0;
      fd_flush     = 1'b0;
      id_ex_bubble = 1'b1;
      halted       = 1'b0;
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_STATS_EN
  logic             stallEvent;
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q;

  assign stallEvent = (state_q == STALL) |
                      ((state_q == RUN) & ~ex_jump_taken & hazard);

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stallEvent && (stallCnt_q != {CNT_W{1'b1}})) stallCnt_q <= stallCnt_q + 1'b1;
      if (fd_flush && (flushCnt_q != {CNT_W{1'b1}})) flushCnt_q <= flushCnt_q + 1'b1;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=2)
// share stimulus; expected values are hand-computed per instance.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, id_halt, ex_reg_wrenable, ex_mem_to_reg, ex_jump_taken;

  logic        aPcEn, aFdEn, aFdFlush, aBubble, aHalted;
  logic [2:0]  aState;
  logic [15:0] aStallCnt, aFlushCnt;
  logic        bPcEn, bFdEn, bFdFlush, bBubble, bHalted;
  logic [2:0]  bState;
  logic [1:0]  bStallCnt, bFlushCnt;

  int errorCount = 0;
  int checkCount = 0;

  pipe_ctrl #(.LOAD_LAT(1), .DEPTH(3), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_reg_wrenable(ex_reg_wrenable),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_jump_taken(ex_jump_taken),
    .pc_en(aPcEn), .fd_en(aFdEn), .fd_flush(aFdFlush), .id_ex_bubble(aBubble),
    .halted(aHalted), .state(aState), .stall_cnt(aStallCnt), .flush_cnt(aFlushCnt)
  );

  pipe_ctrl #(.LOAD_LAT(3), .DEPTH(3), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_reg_wrenable(ex_reg_wrenable),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_jump_taken(ex_jump_taken),
    .pc_en(bPcEn), .fd_en(bFdEn), .fd_flush(bFdFlush), .id_ex_bubble(bBubble),
    .halted(bHalted), .state(bState), .stall_cnt(bStallCnt), .flush_cnt(bFlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int st(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Waits for the falling edge, drives one cycle of inputs, then settles before checks.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                               input logic halt, input logic [4:0] rd, input logic wr,
                               input logic m2r, input logic jump);
    @(negedge clk);
    id_rs1          = rs1;
    id_rs2          = rs2;
    id_uses_rs2     = uses;
    id_halt         = halt;
    ex_rd           = rd;
    ex_reg_wrenable = wr;
    ex_mem_to_reg   = m2r;
    ex_jump_taken   = jump;
    #1;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; id_halt = 1'b0;
    ex_rd = 5'd0; ex_reg_wrenable = 1'b0; ex_mem_to_reg = 1'b0; ex_jump_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_state", aState, 0);
    checkOutput("rst_pc_en", aPcEn, 0);
    checkOutput("rst_fd_en", aFdEn, 0);
    checkOutput("rst_fd_flush", aFdFlush, 0);
    checkOutput("rst_bubble", aBubble, 1);
    checkOutput("rst_halted", aHalted, 0);
    checkOutput("rst_stall_cnt", aStallCnt, 0);
    checkOutput("rst_flush_cnt", aFlushCnt, 0);
    checkOutput("rst_b_pc_en", bPcEn, 0);
    rst_n = 1'b1;

    idle();
    checkOutput("run_pc_en", aPcEn, 1);
    checkOutput("run_fd_en", aFdEn, 1);
    checkOutput("run_bubble", aBubble, 0);

    // Load-use via rs1, LAT=1 on A and LAT=3 on B
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    checkOutput("lu1_pc_en", aPcEn, 0);
    checkOutput("lu1_fd_en", aFdEn, 0);
    checkOutput("lu1_bubble", aBubble, 1);
    checkOutput("lu1_state", aState, 0);
    checkOutput("lu1_b_bubble", bBubble, 1);
    idle();
    checkOutput("lu1_after_state", aState, 0);
    checkOutput("lu1_after_pc_en", aPcEn, 1);
    checkOutput("lu1_stall_cnt", aStallCnt, st(1));
    checkOutput("lu1_b_state1", bState, 1);
    checkOutput("lu1_b_pc_en1", bPcEn, 0);
    idle();
    checkOutput("lu1_b_state2", bState, 1);
    checkOutput("lu1_b_bubble2", bBubble, 1);
    idle();
    checkOutput("lu1_b_state3", bState, 0);
    checkOutput("lu1_b_pc_en3", bPcEn, 1);
    checkOutput("lu1_b_stall_cnt", bStallCnt, st(3));

    // Load-use via rs2 on B (LAT=3), then the same with id_uses_rs2 low
    doReset();
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("lu3_b_state0", bState, 0);
    checkOutput("lu3_b_pc_en0", bPcEn, 0);
    checkOutput("lu3_b_bubble0", bBubble, 1);
    idle();
    checkOutput("lu3_b_state1", bState, 1);
    idle();
    checkOutput("lu3_b_state2", bState, 1);
    idle();
    checkOutput("lu3_b_state3", bState, 0);
    checkOutput("lu3_b_pc_en3", bPcEn, 1);
    checkOutput("lu3_b_stall_cnt", bStallCnt, st(3));
    applyStimulus(5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("nors2_b_pc_en", bPcEn, 1);
    checkOutput("nors2_b_bubble", bBubble, 0);
    checkOutput("nors2_a_pc_en", aPcEn, 1);
    idle();
    checkOutput("nors2_b_state", bState, 0);

    // Jump and hazard together: jump wins, FLUSH ignores both
    doReset();
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    checkOutput("jmp_pc_en", aPcEn, 1);
    checkOutput("jmp_fd_en", aFdEn, 1);
    checkOutput("jmp_fd_flush", aFdFlush, 1);
    checkOutput("jmp_bubble", aBubble, 1);
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_state", aState, 2);
    checkOutput("flush_fd_flush", aFdFlush, 1);
    checkOutput("flush_pc_en", aPcEn, 1);
    checkOutput("flush_b_state", bState, 2);
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("jmp_after_state", aState, 0);
    checkOutput("jmp_after_fd_flush", aFdFlush, 0);
    checkOutput("jmp_flush_cnt", aFlushCnt, st(2));
    checkOutput("jmp_stall_cnt", aStallCnt, 0);
    checkOutput("rd0_pc_en", aPcEn, 1);
    checkOutput("rd0_bubble", aBubble, 0);
    checkOutput("rd0_b_pc_en", bPcEn, 1);

    // Halt with DEPTH=3, jumps ignored in DRAIN and HALTED
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_pc_en", aPcEn, 0);
    checkOutput("halt_fd_en", aFdEn, 0);
    checkOutput("halt_bubble", aBubble, 0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain1_state", aState, 3);
    checkOutput("drain1_bubble", aBubble, 1);
    checkOutput("drain1_halted", aHalted, 0);
    checkOutput("drain1_pc_en", aPcEn, 0);
    idle();
    checkOutput("drain2_state", aState, 3);
    idle();
    checkOutput("drain3_state", aState, 3);
    idle();
    checkOutput("halted_state", aState, 4);
    checkOutput("halted_flag", aHalted, 1);
    checkOutput("halted_bubble", aBubble, 1);
    checkOutput("halted_pc_en", aPcEn, 0);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("halted_jmp_state", aState, 4);
    checkOutput("halted_jmp_fd_flush", aFdFlush, 0);
    idle();
    checkOutput("halted_hold_state", aState, 4);
    checkOutput("halted_hold_b", bHalted, 1);

    // Reset asserted in the second DRAIN cycle
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    checkOutput("mid_drain_state", aState, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_state", aState, 0);
    checkOutput("mid_rst_pc_en", aPcEn, 0);
    checkOutput("mid_rst_bubble", aBubble, 1);
    checkOutput("mid_rst_halted", aHalted, 0);
    rst_n = 1'b1;
    idle();
    checkOutput("post_rst_state", aState, 0);
    checkOutput("post_rst_pc_en", aPcEn, 1);
    idle();
    checkOutput("post_rst_state2", aState, 0);

    // Saturation: two hazards give B six stall edges, two jumps give four flush edges
    doReset();
    for (int h = 0; h < 2; h++) begin
      applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      repeat (3) idle();
    end
    checkOutput("sat_b_stall_cnt", bStallCnt, st(3));
    checkOutput("sat_a_stall_cnt", aStallCnt, st(2));
    for (int j = 0; j < 2; j++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      idle();
    end
    idle();
    checkOutput("sat_b_flush_cnt", bFlushCnt, st(3));
    checkOutput("sat_a_flush_cnt", aFlushCnt, st(4));

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
